// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - ID-stage hazard scoreboard with forwarding, load-use stall and branch flush
module pipe_hazard_scoreboard #(
   parameter  int DEPTH    = 3,
   parameter  int ADDR_W   = 5,
   parameter  int LOAD_LAT = 1,
   parameter  int BR_FLUSH = 1,
   localparam int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_wr_en,
   input  logic [ADDR_W-1:0] id_wr_addr,
   input  logic              id_is_load,
   input  logic              id_jump_or_branch,
   input  logic              mio_ready,
   output logic              issue,
   output logic              stall,
   output logic              flush_if,
   output logic [SEL_W-1:0]  fwd_rs_sel,
   output logic [SEL_W-1:0]  fwd_rt_sel,
   output logic [31:0]       stall_count
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [2:0]        fc_q, fc_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  wr_q, wr_d;
   logic [DEPTH-1:0]  load_q, load_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];

   logic [SEL_W-1:0]  rs_sel, rt_sel;
   logic              rs_hz, rt_hz, hz, eff_valid, issue_w, stall_w;

   // Scan oldest to youngest so the youngest matching entry is the last one to win.
   always_comb begin
      rs_sel = '0;
      rt_sel = '0;
      rs_hz  = 1'b0;
      rt_hz  = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (valid_q[k] && wr_q[k] && addr_q[k] != '0 && addr_q[k] == id_rs && id_uses_rs) begin
            rs_sel = SEL_W'(k + 1);
            rs_hz  = (k < LOAD_LAT) && load_q[k];
         end
         if (valid_q[k] && wr_q[k] && addr_q[k] != '0 && addr_q[k] == id_rt && id_uses_rt) begin
            rt_sel = SEL_W'(k + 1);
            rt_hz  = (k < LOAD_LAT) && load_q[k];
         end
      end
   end

   assign hz        = rs_hz || rt_hz;
   assign eff_valid = id_valid && (state_q == RUN);
   assign stall_w   = eff_valid && (hz || !mio_ready);
   assign issue_w   = eff_valid && !hz && mio_ready;

   assign issue       = issue_w && !rst;
   assign stall       = stall_w && !rst;
   assign flush_if    = (state_q == FLUSH) && !rst;
   assign fwd_rs_sel  = rst ? '0 : rs_sel;
   assign fwd_rt_sel  = rst ? '0 : rt_sel;
   assign stall_count = rst ? '0 : cnt_q;

   always_comb begin
      state_d = state_q;
      fc_d    = fc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wr_d    = wr_q;
      load_d  = load_q;
      for (int k = 0; k < DEPTH; k++) addr_d[k] = addr_q[k];
      // A memory wait freezes everything, including a pending hazard count.
      if (mio_ready) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            load_d[k]  = load_q[k-1];
            addr_d[k]  = addr_q[k-1];
         end
         valid_d[0] = issue_w;
         wr_d[0]    = issue_w && id_wr_en;
         load_d[0]  = issue_w && id_is_load;
         addr_d[0]  = issue_w ? id_wr_addr : '0;
         if (eff_valid && hz && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
         case (state_q)
            RUN: begin
               if (issue_w && id_jump_or_branch && BR_FLUSH > 0) begin
                  state_d = FLUSH;
                  fc_d    = 3'(BR_FLUSH);
               end
            end
            FLUSH: begin
               fc_d = fc_q - 3'd1;
               if (fc_q <= 3'd1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         fc_q    <= '0;
         cnt_q   <= '0;
         valid_q <= '0;
         wr_q    <= '0;
         load_q  <= '0;
         for (int k = 0; k < DEPTH; k++) addr_q[k] <= '0;
      end else begin
         state_q <= state_d;
         fc_q    <= fc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wr_q    <= wr_d;
         load_q  <= load_d;
         for (int k = 0; k < DEPTH; k++) addr_q[k] <= addr_d[k];
      end
   end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed checks of pipe_hazard_scoreboard (DEPTH 3, LOAD_LAT 1, BR_FLUSH 2)
module tb_pipe_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_wr_addr;
   logic        id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_jump_or_branch;
   logic        mio_ready;
   logic        issue, stall, flush_if;
   logic [1:0]  fwd_rs_sel, fwd_rt_sel;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_scoreboard #(
      .DEPTH(3), .ADDR_W(5), .LOAD_LAT(1), .BR_FLUSH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
      .id_jump_or_branch(id_jump_or_branch), .mio_ready(mio_ready),
      .issue(issue), .stall(stall), .flush_if(flush_if),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic we,
                        input logic [4:0] wa, input logic ld, input logic jb);
      id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_jump_or_branch = jb;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; mio_ready = 1'b1;
      @(posedge clk); #1;
      drive(1, 5'd3, 1, 5'd3, 1, 1, 5'd3, 0, 1);
      chk("rst_issue", issue, 0);
      chk("rst_stall", stall, 0);
      chk("rst_flush", flush_if, 0);
      chk("rst_count", stall_count, 0);
      tick();
      rst = 1'b0;

      // forwarding from EX and MEM
      drive(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
      chk("add_issue", issue, 1);
      chk("add_rs_sel", fwd_rs_sel, 0);
      tick();
      drive(1, 5'd3, 1, 5'd3, 1, 1, 5'd4, 0, 0);
      chk("sub_rs_sel", fwd_rs_sel, 1);
      chk("sub_rt_sel", fwd_rt_sel, 1);
      chk("sub_stall", stall, 0);
      chk("sub_issue", issue, 1);
      tick();
      drive(1, 5'd3, 1, 5'd0, 0, 1, 5'd8, 0, 0);
      chk("mem_rs_sel", fwd_rs_sel, 2);
      chk("mem_rt_sel", fwd_rt_sel, 0);
      tick();

      // load-use
      drive(1, 5'd29, 1, 5'd0, 0, 1, 5'd5, 1, 0);
      chk("lw_issue", issue, 1);
      tick();
      drive(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0);
      chk("lu_stall", stall, 1);
      chk("lu_issue", issue, 0);
      chk("lu_rs_sel", fwd_rs_sel, 1);
      chk("lu_rt_sel", fwd_rt_sel, 0);
      chk("lu_count0", stall_count, 0);
      tick();
      chk("lu2_stall", stall, 0);
      chk("lu2_issue", issue, 1);
      chk("lu2_rs_sel", fwd_rs_sel, 2);
      chk("lu2_count", stall_count, 1);
      tick();

      // $0 never forwards; youngest writer wins
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0);
      tick();
      drive(1, 5'd0, 1, 5'd0, 1, 1, 5'd7, 0, 0);
      chk("r0_rs_sel", fwd_rs_sel, 0);
      chk("r0_rt_sel", fwd_rt_sel, 0);
      chk("r0_stall", stall, 0);
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0);
      tick();
      drive(1, 5'd7, 1, 5'd7, 1, 0, 5'd0, 0, 0);
      chk("young_rs_sel", fwd_rs_sel, 1);
      chk("young_rt_sel", fwd_rt_sel, 1);
      tick();

      // taken branch, two flush slots
      drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
      chk("br_issue", issue, 1);
      chk("br_flush_t", flush_if, 0);
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0);
      chk("br_flush_t1", flush_if, 1);
      chk("br_issue_t1", issue, 0);
      tick();
      chk("br_flush_t2", flush_if, 1);
      chk("br_issue_t2", issue, 0);
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      chk("br_flush_t3", flush_if, 0);
      chk("br_issue_t3", issue, 1);
      tick();

      // flush extended by a memory wait
      drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
      chk("br2_issue", issue, 1);
      tick();
      mio_ready = 1'b0;
      drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      chk("br2_flush_t1", flush_if, 1);
      chk("br2_stall_t1", stall, 0);
      tick();
      mio_ready = 1'b1; #2;
      chk("br2_flush_t2", flush_if, 1);
      tick();
      chk("br2_flush_t3", flush_if, 1);
      chk("br2_issue_t3", issue, 0);
      tick();
      chk("br2_flush_t4", flush_if, 0);
      chk("br2_issue_t4", issue, 1);
      tick();

      // load-use during a memory wait
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 1, 0);
      tick();
      mio_ready = 1'b0;
      drive(1, 5'd10, 1, 5'd0, 0, 1, 5'd11, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("wait_stall", stall, 1);
         chk("wait_issue", issue, 0);
         chk("wait_rs_sel", fwd_rs_sel, 1);
         chk("wait_count", stall_count, 1);
         tick();
      end
      mio_ready = 1'b1; #2;
      chk("ready_stall", stall, 1);
      chk("ready_count", stall_count, 1);
      tick();
      chk("ready2_issue", issue, 1);
      chk("ready2_rs_sel", fwd_rs_sel, 2);
      chk("ready2_count", stall_count, 2);
      tick();

      // reset mid-flush with three valid entries
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd12, 0, 0);
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd13, 0, 0);
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd14, 0, 1);
      chk("jal_issue", issue, 1);
      tick();
      drive(1, 5'd14, 1, 5'd13, 1, 0, 5'd0, 0, 0);
      chk("pre_rst_flush", flush_if, 1);
      rst = 1'b1; #2;
      chk("in_rst_flush", flush_if, 0);
      chk("in_rst_rs_sel", fwd_rs_sel, 0);
      tick();
      rst = 1'b0; #2;
      chk("post_rst_rs_sel", fwd_rs_sel, 0);
      chk("post_rst_rt_sel", fwd_rt_sel, 0);
      chk("post_rst_flush", flush_if, 0);
      chk("post_rst_count", stall_count, 0);
      chk("post_rst_stall", stall, 0);
      chk("post_rst_issue", issue, 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised successor to the ID-stage hazard logic: tracks every in-flight register write across a configurable number of post-ID stages and resolves data hazards by forwarding instead of blanket stalling. Stalls only on load-use and memory wait; handles taken control transfers with a counted fetch flush. Sits beside the ID-stage decoder, fed by decoded fields, driving the PC/IF-ID enables and the operand-bypass multiplexers.

## Interface
- `DEPTH`, 3: number of tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB); range 1–7.
- `ADDR_W`, 5: register address width.
- `LOAD_LAT`, 1: entries with index < `LOAD_LAT` holding a load cannot forward; range 0–`DEPTH`.
- `BR_FLUSH`, 1: fetch slots squashed after a taken jump/branch issues; range 0–7.
- `SEL_W`, `$clog2(DEPTH+1)`: forward-select width (localparam).

- `clk` in 1: the single clock; all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in `ADDR_W`: source addresses.
- `id_uses_rs`, `id_uses_rt` in 1: the source is actually read.
- `id_wr_en` in 1: the instruction writes the register file.
- `id_wr_addr` in `ADDR_W`: destination address.
- `id_is_load` in 1: the write data comes from memory.
- `id_jump_or_branch` in 1: taken control transfer (j/jal/jr/taken beq/bne).
- `mio_ready` in 1: memory ready; 0 freezes the whole pipeline.
- `issue` out 1: the ID instruction enters entry 0 this cycle.
- `stall` out 1: hold PC and IF/ID.
- `flush_if` out 1: IF/ID is squashed this cycle.
- `fwd_rs_sel`, `fwd_rt_sel` out `SEL_W`: 0 = register file, k+1 = entry k result.
- `stall_count` out 32: hazard-stall cycles since reset, saturating at 0xFFFFFFFF.

## Operation
- Scoreboard: `DEPTH` entries of {valid, wr_en, addr, is_load}, shifted on each advance (`mio_ready`=1). Entry 0 receives the issued instruction or a bubble; the last entry is dropped.
- Match for rs: valid && wr_en && addr == id_rs && addr != 0 && id_uses_rs. The youngest matching entry (smallest k) wins. The rt match is identical.
- `fwd_*_sel` = k+1 for the winning entry, else 0. It is valid regardless of stall.
- Load-use: `hz` = 1 when a winning entry k < `LOAD_LAT` has is_load set.
- `eff_valid` = id_valid && state == RUN. The squash applies when `eff_valid`=0.
- `stall` = `eff_valid` && (`hz` || !mio_ready).
- `issue` = `eff_valid` && !`hz` && mio_ready.
- FSM with states RUN and FLUSH, and a 3-bit counter `fc`:
  - RUN → FLUSH when `issue` && id_jump_or_branch && `BR_FLUSH` > 0; load `fc` = `BR_FLUSH`.
  - In FLUSH, `flush_if`=1 and ID contents are treated as bubbles. `fc` decrements on each cycle with mio_ready=1, and the FSM returns to RUN when `fc` reaches 0.
  - If `BR_FLUSH` = 0, the FSM never leaves RUN.
- `stall_count` increments on cycles where `eff_valid` && `hz` && mio_ready. Memory waits are not counted.
- Simultaneous `hz` and !mio_ready: freeze; no bubble insertion and no count.

## Timing
- Forward selects, `stall`, `issue` and `flush_if` are combinational from inputs and current state, in the same cycle.
- A load in EX followed by a dependent instruction gives exactly `LOAD_LAT` stall cycles (1 by default). The dependent instruction then issues with sel = `LOAD_LAT`+1.
- A taken transfer issues in cycle t. `flush_if`=1 for cycles t+1 … t+`BR_FLUSH`, extended by any mio_ready=0 cycles.
- Reset, applied at any point: all entries invalid, state RUN, `fc`=0, `stall_count`=0. With rst=1 all outputs are forced to 0. The first cycle after reset always forwards sel 0.
- mio_ready=0 holds entries, `fc`, state and `stall_count` unchanged. Outputs still reflect the held state.

## Test plan
- add $3 issues, then sub $4,$3,$3 the next cycle → `fwd_rs_sel`=`fwd_rt_sel`=1, `stall`=0, `issue`=1. One cycle later, an unrelated instruction reads $3 → sel=2.
- lw $5 issues, then add $6,$5,$0 → `stall`=1 and `issue`=0 for 1 cycle, `stall_count`=1. The next cycle gives `fwd_rs_sel`=2 and `issue`=1.
- Write to $0 in entry 0, then an instruction reads $0 → sel=0 and no stall. $7 written in entries 0 and 1 → sel=1 (youngest wins).
- With `BR_FLUSH`=2, beq taken issues at t → `flush_if`=1 at t+1 and t+2 with `issue`=0, back to RUN at t+3. Dropping mio_ready=0 at t+1 extends the flush to t+3.
- Load-use hazard while mio_ready=0 for 3 cycles → `stall`=1, scoreboard frozen, `stall_count` unchanged. The hazard stall counts only once ready returns.
- Assert rst mid-FLUSH with 3 valid entries → next cycle all sels=0, `flush_if`=0, `stall_count`=0, and a dependent instruction issues without stalling.
